// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN evaluator: token types, opcodes,
// error codes and sequencer states.
package rpn_pkg;

    localparam logic [1:0] TOK_NUM = 2'b00;
    localparam logic [1:0] TOK_OP  = 2'b01;
    localparam logic [1:0] TOK_END = 2'b10;
    localparam logic [1:0] TOK_RSV = 2'b11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_UNDER = 3'd1;
    localparam logic [2:0] ERR_OVER  = 3'd2;
    localparam logic [2:0] ERR_DIV0  = 3'd3;
    localparam logic [2:0] ERR_BADOP = 3'd4;
    localparam logic [2:0] ERR_END   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP_B,
        S_POP_A,
        S_EXEC,
        S_RESULT,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/rpn_eval_ctrl_if.sv
// Token handshake between the parser (master) and the
// RPN sequencer (slave).
interface rpn_eval_ctrl_if;

    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_type;
    logic [7:0] tok_data;

    modport master (
        output tok_valid,
        output tok_type,
        output tok_data,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_type,
        input  tok_data,
        output tok_ready
    );

endinterface

// File: rtl/rpn_alu.sv
// Unsigned 8-bit ALU for the RPN evaluator; all results wrap mod 256.
module rpn_alu
    import rpn_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] y,
    output logic       div_zero
);

    logic [15:0] prod;

    assign prod     = {8'd0, a} * {8'd0, b};
    assign div_zero = (op == OP_DIV) && (b == 8'd0);

    always_comb begin
        y = 8'd0;
        unique case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = prod[7:0];
            OP_DIV:  y = (b == 8'd0) ? 8'd0 : a / b;
            default: y = 8'd0;
        endcase
    end

endmodule

// File: rtl/rpn_eval_ctrl.sv
// RPN token sequencer driving an external operand stack;
// returns the final value or an error code.
module rpn_eval_ctrl
    import rpn_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rpn_eval_ctrl_if.slave       tok,
    output logic                 stk_push_en,
    output logic                 stk_pop_en,
    output logic [7:0]           stk_data_in,
    input  logic [7:0]           stk_data_out,
    input  logic                 stk_is_empty,
    output logic                 res_valid,
    output logic [7:0]           res_data,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic                 busy
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);

    state_e         state_q, state_d;
    logic [DW-1:0]  depth_q, depth_d;
    logic [7:0]     hold_q, hold_d;
    logic [7:0]     a_q, a_d;
    logic [7:0]     b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic [7:0]     res_q, res_d;
    logic           err_q, err_d;
    logic [2:0]     code_q, code_d;
    logic [7:0]     alu_y;
    logic           alu_dz;
    logic           exec_dz;

    rpn_alu u_alu (
        .a        (a_q),
        .b        (b_q),
        .op       (op_q),
        .y        (alu_y),
        .div_zero (alu_dz)
    );

    assign exec_dz = (state_q == S_EXEC) && alu_dz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            hold_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            res_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            hold_q  <= hold_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        hold_d  = hold_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = 1'b0;
        code_d  = code_q;
        unique case (state_q)
            S_IDLE: if (tok.tok_valid) begin
                unique case (1'b1)
                    tok.tok_type == TOK_NUM: begin
                        if (depth_q == DMAX) begin
                            err_d   = 1'b1;
                            code_d  = ERR_OVER;
                            state_d = S_DRAIN;
                        end else begin
                            hold_d  = tok.tok_data;
                            state_d = S_PUSH;
                        end
                    end
                    tok.tok_type == TOK_END: begin
                        // top is already valid; capture so it shows with res_valid
                        if (depth_q == DW'(1)) begin
                            res_d   = stk_data_out;
                            state_d = S_RESULT;
                        end else if (depth_q != '0) begin
                            err_d   = 1'b1;
                            code_d  = ERR_END;
                            state_d = S_DRAIN;
                        end
                    end
                    default: begin
                        if (tok.tok_type == TOK_RSV || tok.tok_data[2]) begin
                            err_d   = 1'b1;
                            code_d  = ERR_BADOP;
                            state_d = S_DRAIN;
                        end else if (depth_q < DW'(2)) begin
                            err_d   = 1'b1;
                            code_d  = ERR_UNDER;
                            state_d = S_DRAIN;
                        end else begin
                            op_d    = tok.tok_data[2:0];
                            state_d = S_POP_B;
                        end
                    end
                endcase
            end
            S_PUSH: begin
                depth_d = depth_q + DW'(1);
                state_d = S_IDLE;
            end
            S_POP_B: begin
                b_d     = stk_data_out;
                depth_d = depth_q - DW'(1);
                state_d = S_POP_A;
            end
            S_POP_A: begin
                a_d     = stk_data_out;
                depth_d = depth_q - DW'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (alu_dz) begin
                    code_d  = ERR_DIV0;
                    state_d = S_DRAIN;
                end else begin
                    hold_d  = alu_y;
                    state_d = S_PUSH;
                end
            end
            S_RESULT: begin
                depth_d = '0;
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (depth_q != '0) depth_d = depth_q - DW'(1);
                if (depth_q <= DW'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tok.tok_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign stk_push_en   = (state_q == S_PUSH);
    assign stk_data_in   = hold_q;
    assign stk_pop_en    = (state_q == S_POP_B) || (state_q == S_POP_A) ||
                           (state_q == S_RESULT) ||
                           ((state_q == S_DRAIN) && (depth_q != '0));
    assign res_valid     = (state_q == S_RESULT);
    assign res_data      = res_q;
    assign err           = err_q || exec_dz;
    assign err_code      = exec_dz ? ERR_DIV0 : code_q;

    a_depth_empty: assert property (@(posedge clk) disable iff (rst)
        (depth_q == '0) == stk_is_empty);
    a_push_pop: assert property (@(posedge clk) disable iff (rst)
        !(stk_push_en && stk_pop_en));

endmodule

// File: tb/tb_rpn_eval_ctrl.sv
// Directed bench for rpn_eval_ctrl with a behavioural operand stack
// sized to the DUT depth.
module tb_rpn_eval_ctrl;
    import rpn_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stk_push_en, stk_pop_en;
    logic [7:0] stk_data_in, stk_data_out;
    logic       stk_is_empty;
    logic       res_valid, err, busy;
    logic [7:0] res_data;
    logic [2:0] err_code;

    int n_checks = 0;
    int n_fail   = 0;
    int stk_bad  = 0;

    logic [7:0] mem [16];
    logic [4:0] sp;

    rpn_eval_ctrl_if tok_if ();

    rpn_eval_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .tok          (tok_if.slave),
        .stk_push_en  (stk_push_en),
        .stk_pop_en   (stk_pop_en),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_is_empty (stk_is_empty),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .err          (err),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (stk_push_en) begin
            if (sp == 5'(DEPTH)) stk_bad <= stk_bad + 1;
            else begin
                mem[sp[3:0]] <= stk_data_in;
                sp <= sp + 5'd1;
            end
        end else if (stk_pop_en) begin
            if (sp == 5'd0) stk_bad <= stk_bad + 1;
            else sp <= sp - 5'd1;
        end
    end

    assign stk_data_out = (sp != 5'd0) ? mem[sp[3:0] - 4'd1] : 8'h00;
    assign stk_is_empty = (sp == 5'd0);

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!tok_if.tok_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tok_if.tok_ready) chk("send_timeout", 0, 1);
        tok_if.tok_valid = 1'b1;
        tok_if.tok_type  = t;
        tok_if.tok_data  = d;
        @(posedge clk);
        #1;
        tok_if.tok_valid = 1'b0;
    endtask

    task automatic num(input logic [7:0] v, input string tag);
        send(TOK_NUM, v);
        chk({tag, "_push"}, int'(stk_push_en), 1);
        chk({tag, "_pdata"}, int'(stk_data_in), int'(v));
    endtask

    task automatic do_op(input logic [2:0] code, input string tag);
        int n = 1;
        send(TOK_OP, {5'd0, code});
        while (!tok_if.tok_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, 5);
    endtask

    task automatic do_end(input int exp, input string tag);
        send(TOK_END, 8'd0);
        chk({tag, "_valid"}, int'(res_valid), 1);
        chk({tag, "_data"}, int'(res_data), exp);
        @(posedge clk);
        #1;
        chk({tag, "_vfall"}, int'(res_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_empty"}, int'(sp), 0);
    endtask

    task automatic drain(input int pops_exp, input int cyc_exp,
                         input string tag);
        int pops = 0;
        int n = 0;
        while (busy && n < 40) begin
            if (stk_pop_en) pops++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_pops"}, pops, pops_exp);
        chk({tag, "_cyc"}, n, cyc_exp);
        chk({tag, "_empty"}, int'(sp), 0);
        chk({tag, "_err0"}, int'(err), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, int'(tok_if.tok_ready), 1);
        chk({tag, "_push"}, int'(stk_push_en), 0);
        chk({tag, "_pop"}, int'(stk_pop_en), 0);
        chk({tag, "_rv"}, int'(res_valid), 0);
        chk({tag, "_rd"}, int'(res_data), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_code"}, int'(err_code), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        tok_if.tok_valid = 1'b0;
        tok_if.tok_type  = TOK_NUM;
        tok_if.tok_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b0;

        num(8'd3, "t1a");
        num(8'd4, "t1b");
        do_op(OP_ADD, "t1op");
        do_end(7, "t1");

        num(8'd2, "t2a");
        num(8'd3, "t2b");
        num(8'd4, "t2c");
        do_op(OP_MUL, "t2mul");
        do_op(OP_ADD, "t2add");
        do_end(14, "t2");

        num(8'd200, "t3a");
        num(8'd100, "t3b");
        do_op(OP_ADD, "t3op");
        do_end(44, "t3");
        num(8'd5, "t4a");
        num(8'd9, "t4b");
        do_op(OP_SUB, "t4op");
        do_end(252, "t4");
        num(8'd20, "t5a");
        num(8'd20, "t5b");
        do_op(OP_MUL, "t5op");
        do_end(144, "t5");
        num(8'd17, "t6a");
        num(8'd5, "t6b");
        do_op(OP_DIV, "t6op");
        do_end(3, "t6");

        num(8'd5, "dz_a");
        num(8'd0, "dz_b");
        send(TOK_OP, {5'd0, OP_DIV});
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("dz_err", int'(err), 1);
        chk("dz_code", int'(err_code), 3);
        chk("dz_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        drain(0, 1, "dz_drain");
        chk("dz_held", int'(err_code), 3);

        for (int i = 1; i <= 4; i++) num(8'(i), "ovf_n");
        send(TOK_NUM, 8'd5);
        chk("ovf_err", int'(err), 1);
        chk("ovf_code", int'(err_code), 2);
        drain(4, 4, "ovf_drain");

        send(TOK_OP, {5'd0, OP_ADD});
        chk("und_err", int'(err), 1);
        chk("und_code", int'(err_code), 1);
        drain(0, 1, "und_drain");

        num(8'd1, "mal_a");
        num(8'd2, "mal_b");
        send(TOK_END, 8'd0);
        chk("mal_err", int'(err), 1);
        chk("mal_code", int'(err_code), 5);
        chk("mal_rv", int'(res_valid), 0);
        drain(2, 2, "mal_drain");

        send(TOK_OP, 8'd6);
        chk("bad_err", int'(err), 1);
        chk("bad_code", int'(err_code), 4);
        drain(0, 1, "bad_drain");

        num(8'd9, "rsv_a");
        num(8'd9, "rsv_b");
        send(TOK_RSV, 8'd0);
        chk("rsv_code", int'(err_code), 4);
        drain(2, 2, "rsv_drain");

        send(TOK_END, 8'd0);
        chk("end0_rv", int'(res_valid), 0);
        chk("end0_err", int'(err), 0);
        chk("end0_busy", int'(busy), 0);

        num(8'd1, "ra_a");
        num(8'd2, "ra_b");
        send(TOK_OP, {5'd0, OP_ADD});
        @(posedge clk);
        #1;
        chk("ra_popa", int'(stk_pop_en), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("ra");
        rst = 1'b0;
        num(8'd1, "ra_c");
        num(8'd1, "ra_d");
        do_op(OP_ADD, "ra_op");
        do_end(2, "ra");

        chk("stk_misuse", stk_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rpn_eval_ctrl.md
# rpn_eval_ctrl

Sequencer that evaluates a Reverse-Polish token stream for the calculator using the team's 8-bit operand stack as storage. It accepts number, operator and end tokens over a valid/ready handshake and drives the stack's push/pop/data ports. It computes results with an 8-bit ALU and returns the final value, or an error code, to the display/output logic. It sits between the token parser and the operand stack instance.

## Interface
- DEPTH, 16: maximum operand count; must not exceed the stack instance size; depth counter width is clog2(DEPTH+1).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; must be wired to the stack instance's rst as well.
- tok_valid  in  1  token present.
- tok_ready  out  1  token accepted on clk edge when tok_valid & tok_ready.
- tok_type  in  2  00 number, 01 operator, 10 end, 11 reserved (treated as bad op).
- tok_data  in  8  number value, or opcode in [2:0] (0 add, 1 sub, 2 mul, 3 div, 4-7 illegal).
- stk_push_en  out  1  push to stack.
- stk_pop_en  out  1  pop from stack.
- stk_data_in  out  8  push data.
- stk_data_out  in  8  stack top (combinational, valid when non-empty).
- stk_is_empty  in  1  stack empty (checked against the internal depth counter in assertions only).
- res_valid  out  1  one-cycle pulse, result on res_data.
- res_data  out  8  final result, held until next res_valid.
- err  out  1  one-cycle pulse on error detection.
- err_code  out  3  1 underflow, 2 overflow, 3 divide-by-zero, 4 bad op, 5 malformed end; held until next err.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, PUSH, POP_B, POP_A, EXEC, RESULT, DRAIN.
- IDLE: tok_ready=1. On accept:
  - number: if depth==DEPTH then err, code 2, go to DRAIN. Otherwise latch value into hold reg, go to PUSH.
  - operator: if opcode>3 or tok_type==11 then err, code 4, DRAIN. If depth<2 then err, code 1, DRAIN. Otherwise latch op, go to POP_B.
  - end: if depth==1 then RESULT. Otherwise err, code 5, DRAIN. With depth 0 this is a normal idle return, no res_valid.
- PUSH: stk_push_en=1, stk_data_in=hold, depth+1, go to IDLE.
- POP_B: b<=stk_data_out, stk_pop_en=1, depth-1, go to POP_A.
- POP_A: a<=stk_data_out (new top), stk_pop_en=1, depth-1, go to EXEC.
- EXEC: if op==div and b==0 then err, code 3, DRAIN. Otherwise hold<=alu(a,op,b), go to PUSH.
- RESULT: res_data<=stk_data_out, res_valid=1, stk_pop_en=1, depth 0, go to IDLE.
- DRAIN: stk_pop_en=1 and depth-1 per cycle while depth>0. Go to IDLE the cycle depth reaches 0. If depth is already 0, go to IDLE after one cycle.
- Arithmetic is unsigned 8-bit and wraps mod 256:
  - add: a+b.
  - sub: a-b.
  - mul: low 8 bits of the 16-bit product.
  - div: floor(a/b).
- stk_push_en and stk_pop_en are never both high.

## Timing
- All outputs are registered or decoded from state only; no combinational path from tok_* to stk_*.
- Reset values: state IDLE, depth 0, tok_ready 1, stk_push_en 0, stk_pop_en 0, res_valid 0, res_data 0, err 0, err_code 0, busy 0.
- Number: accepted at edge N, stk_push_en high in cycle N+1, next token accepted at N+2.
- Operator: accepted at N; POP_B N+1, POP_A N+2, EXEC N+3, PUSH N+4; tok_ready high again at N+5.
- End: RESULT in N+1 with res_valid high; IDLE at N+2.
- err pulses in the cycle after the offending accept, or in the EXEC cycle for divide-by-zero. DRAIN follows and takes max(depth,1) cycles.
- Synchronous rst mid-operation aborts any state to IDLE next edge. The stack resets together, so no drain is needed.

## Structure
- Package rpn_pkg holds:
  - tok_type encodings;
  - opcode localparams;
  - err_code localparams;
  - state enum.
- Sub-module rpn_alu: combinational, inputs a, b, op; outputs y and div_zero. Instantiated once.
- The stack itself is instantiated by the parent, not inside this block.

## Test plan
- Tokens 3, 4, +, end: res_valid with res_data=7 exactly 1 cycle after the end accept; stack empty after.
- Tokens 2, 3, 4, *, +, end: res_data=14; operator latency is 5 cycles each.
- Tokens 200, 100, + and 5, 9, -: results 44 and 252 (wrap). Tokens 20, 20, *: result 144. Tokens 17, 5, /: result 3.
- Tokens 5, 0, /: err with code 3 in the EXEC cycle; DRAIN takes 1 cycle; busy falls; stack empty.
- With DEPTH=4, five numbers: fifth gives err code 2 and DRAIN pops 4. A lone +: err code 1. Tokens 1, 2, end: err code 5. Opcode 6: err code 4.
- rst asserted during POP_A: next cycle all outputs at reset values; then 1, 1, +, end gives res_data=2.
